dot_accum_requant: RTL and testbench

DOT_ACCUM_REQUANT -- requirements
Module: dot_accum_requant

---
 rtl/dot_accum_requant_if.sv | 30 +++
 rtl/dot_accum_requant.sv | 134 +++++++++++++
 tb/tb_dot_accum_requant.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dot_accum_requant_if.sv
// Bundle of the datapath, config and output handshake signals for dot_accum_requant.
// master drives partials, config and out_ready; slave (the block) drives results and status.
interface dot_accum_requant_if #(
    parameter int IWIDTH = 32,
    parameter int AWIDTH = 48,
    parameter int OWIDTH = 8,
    parameter int CWIDTH = 8
);
    logic signed [IWIDTH-1:0] in_data;
    logic                     in_valid;
    logic        [CWIDTH-1:0] num_chunks;
    logic signed [AWIDTH-1:0] bias;
    logic        [4:0]        shift;
    logic                     relu_en;
    logic signed [OWIDTH-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic        [CWIDTH-1:0] chunk_idx;
    logic                     ovf_err;

    modport master (
        output in_data, in_valid, num_chunks, bias, shift, relu_en, out_ready,
        input  out_data, out_valid, chunk_idx, ovf_err
    );

    modport slave (
        input  in_data, in_valid, num_chunks, bias, shift, relu_en, out_ready,
        output out_data, out_valid, chunk_idx, ovf_err
    );
endinterface

// File: rtl/dot_accum_requant.sv
// Accumulates signed partial dot products into elements, adds bias, rounds/shifts,
// optional ReLU, saturates. Ports: clk, rst_n (sync, active-low), bus (slave modport).
module dot_accum_requant #(
    parameter int IWIDTH = 32,
    parameter int AWIDTH = 48,
    parameter int OWIDTH = 8,
    parameter int CWIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    dot_accum_requant_if.slave bus
);
    localparam logic signed [AWIDTH:0] ONE = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic signed [AWIDTH:0] OMAX = {{(AWIDTH-OWIDTH+2){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH:0] OMIN = ~OMAX;
    localparam logic [OWIDTH-1:0] OMAX_O = {1'b0, {(OWIDTH-1){1'b1}}};
    localparam logic [OWIDTH-1:0] OMIN_O = ~OMAX_O;

    logic signed [AWIDTH-1:0] acc;
    logic        [CWIDTH-1:0] cnt;
    logic        [CWIDTH-1:0] cap_n;
    logic signed [AWIDTH-1:0] cap_bias;
    logic        [4:0]        cap_shift;
    logic                     cap_relu;
    logic                     done_q;

    logic                     s1_valid;
    logic signed [AWIDTH-1:0] s1_sum;
    logic        [4:0]        s1_shift;
    logic                     s1_relu;

    logic signed [OWIDTH-1:0] out_q;
    logic                     out_valid_q;
    logic                     ovf_q;

    logic                     first;
    logic        [CWIDTH-1:0] eff_n;
    logic        [CWIDTH:0]   next_cnt;
    logic                     done;
    logic signed [AWIDTH-1:0] ext;

    logic signed [AWIDTH:0]   s_ext;
    logic signed [AWIDTH:0]   s_half;
    logic signed [AWIDTH:0]   s_rnd;
    logic signed [AWIDTH:0]   s_shr;
    logic signed [AWIDTH:0]   s_rel;
    logic signed [OWIDTH-1:0] s_sat;

    // Element length comes from the live input on the first partial,
    // from the captured value afterwards; zero means single-partial.
    always_comb begin
        first    = (cnt == '0);
        eff_n    = first ? bus.num_chunks : cap_n;
        next_cnt = {1'b0, cnt} + 1'b1;
        done     = (eff_n == '0) || (next_cnt == {1'b0, eff_n});
        ext      = {{(AWIDTH-IWIDTH){bus.in_data[IWIDTH-1]}}, bus.in_data};
    end

    // One extra bit of headroom so the rounding add cannot wrap.
    always_comb begin
        s_ext  = {s1_sum[AWIDTH-1], s1_sum};
        s_half = (s1_shift == 5'd0) ? '0 : (ONE << (s1_shift - 5'd1));
        s_rnd  = s_ext + s_half;
        s_shr  = s_rnd >>> s1_shift;
        s_rel  = (s1_relu && s_shr[AWIDTH]) ? '0 : s_shr;
        if (s_rel > OMAX) begin
            s_sat = OMAX_O;
        end else if (s_rel < OMIN) begin
            s_sat = OMIN_O;
        end else begin
            s_sat = s_rel[OWIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            cap_n       <= '0;
            cap_bias    <= '0;
            cap_shift   <= '0;
            cap_relu    <= 1'b0;
            done_q      <= 1'b0;
            s1_valid    <= 1'b0;
            s1_sum      <= '0;
            s1_shift    <= '0;
            s1_relu     <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.in_valid) begin
                acc <= first ? ext : acc + ext;
                if (first) begin
                    cap_n     <= bus.num_chunks;
                    cap_bias  <= bus.bias;
                    cap_shift <= bus.shift;
                    cap_relu  <= bus.relu_en;
                end
                if (done) begin
                    cnt    <= '0;
                    done_q <= 1'b1;
                end else begin
                    cnt <= next_cnt[CWIDTH-1:0];
                end
            end

            // S1 reads acc/cap before a back-to-back first partial overwrites them.
            s1_valid <= done_q;
            if (done_q) begin
                s1_sum   <= acc + cap_bias;
                s1_shift <= cap_shift;
                s1_relu  <= cap_relu;
            end

            if (s1_valid) begin
                if (!out_valid_q || bus.out_ready) begin
                    out_q       <= s_sat;
                    out_valid_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.chunk_idx = cnt;
    assign bus.ovf_err   = ovf_q;
endmodule

// File: tb/tb_dot_accum_requant.sv
// Directed, table-driven bench for dot_accum_requant.
// Element vectors in a table plus hand sequences for timing corners.
module tb_dot_accum_requant;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dot_accum_requant_if #(.IWIDTH(32), .AWIDTH(48), .OWIDTH(8), .CWIDTH(8)) bus ();

    dot_accum_requant #(.IWIDTH(32), .AWIDTH(48), .OWIDTH(8), .CWIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0]         n;
        logic signed [47:0] b;
        logic [4:0]         s;
        logic               r;
        int                 np;
        logic signed [31:0] p [4];
        logic signed [7:0]  e;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add_vec(input int i, input int n, input longint b, input int s,
                           input int r, input int np, input int p0, input int p1,
                           input int p2, input int p3, input int e);
        vecs[i].n    = 8'(n);
        vecs[i].b    = 48'(b);
        vecs[i].s    = 5'(s);
        vecs[i].r    = 1'(r);
        vecs[i].np   = np;
        vecs[i].p[0] = 32'(p0);
        vecs[i].p[1] = 32'(p1);
        vecs[i].p[2] = 32'(p2);
        vecs[i].p[3] = 32'(p3);
        vecs[i].e    = 8'(e);
    endtask

    task automatic drive(input logic v, input int d, input int n, input longint b,
                         input int s, input int r);
        bus.in_valid   = v;
        bus.in_data    = 32'(d);
        bus.num_chunks = 8'(n);
        bus.bias       = 48'(b);
        bus.shift      = 5'(s);
        bus.relu_en    = 1'(r);
    endtask

    initial begin
        drive(1'b0, 0, 0, 0, 0, 0);
        bus.out_ready = 1'b1;

        add_vec(0, 4, 10, 0, 0, 4, 5, -3, 20, 7, 39);
        add_vec(1, 1, 0, 4, 0, 1, 24, 0, 0, 0, 2);
        add_vec(2, 1, 0, 4, 0, 1, -24, 0, 0, 0, -1);
        add_vec(3, 1, 0, 4, 0, 1, 5000, 0, 0, 0, 127);
        add_vec(4, 1, 0, 4, 0, 1, -5000, 0, 0, 0, -128);
        add_vec(5, 2, 0, 0, 1, 2, -50, 10, 0, 0, 0);
        add_vec(6, 2, 0, 0, 0, 2, -50, 10, 0, 0, -40);
        add_vec(7, 2, -100, 2, 0, 2, 30, 1, 0, 0, -17);
        add_vec(8, 1, 0, 31, 0, 1, 2147483647, 0, 0, 0, 1);
        add_vec(9, 3, 0, 1, 0, 3, 1, 1, 1, 0, 2);

        tick();
        tick();
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_chunk_idx", bus.chunk_idx, 0);
        chk("rst_ovf_err", bus.ovf_err, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < vecs[i].np; k++) begin
                drive(1'b1, vecs[i].p[k], vecs[i].n, vecs[i].b, vecs[i].s, vecs[i].r);
                tick();
                chk($sformatf("v%0d_chunk%0d", i, k), bus.chunk_idx,
                    (k + 1 == vecs[i].np) ? 0 : k + 1);
            end
            drive(1'b0, 0, 0, 0, 0, 0);
            tick();
            chk($sformatf("v%0d_early_valid", i), bus.out_valid, 0);
            tick();
            chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("v%0d_data", i), bus.out_data, vecs[i].e);
            tick();
            chk($sformatf("v%0d_drop", i), bus.out_valid, 0);
        end

        // num_chunks=0, back-to-back: each partial is its own element, no bubble,
        // and a new element replaces the one accepted in the same cycle.
        drive(1'b1, 3, 0, 0, 0, 0);
        tick();
        chk("nc0_chunk_a", bus.chunk_idx, 0);
        drive(1'b1, 4, 0, 0, 0, 0);
        tick();
        chk("nc0_chunk_b", bus.chunk_idx, 0);
        drive(1'b0, 0, 0, 0, 0, 0);
        tick();
        chk("b2b_valid_a", bus.out_valid, 1);
        chk("b2b_data_a", bus.out_data, 3);
        tick();
        chk("b2b_valid_b", bus.out_valid, 1);
        chk("b2b_data_b", bus.out_data, 4);
        tick();
        chk("b2b_drop", bus.out_valid, 0);

        // Config changes after the first partial are ignored for that element.
        drive(1'b1, 1, 3, 0, 0, 0);
        tick();
        drive(1'b1, 2, 2, 100, 3, 1);
        tick();
        chk("mid_chunk2", bus.chunk_idx, 2);
        drive(1'b1, 3, 2, 100, 3, 1);
        tick();
        chk("mid_chunk3", bus.chunk_idx, 0);
        drive(1'b0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("mid_valid", bus.out_valid, 1);
        chk("mid_data", bus.out_data, 6);
        tick();

        // Backpressure: A held, B dropped, ovf_err sticky.
        bus.out_ready = 1'b0;
        drive(1'b1, 11, 1, 0, 0, 0);
        tick();
        drive(1'b0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("bp_valid_a", bus.out_valid, 1);
        chk("bp_data_a", bus.out_data, 11);
        chk("bp_ovf_pre", bus.ovf_err, 0);
        tick();
        drive(1'b1, 22, 1, 0, 0, 0);
        tick();
        drive(1'b0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_data", bus.out_data, 11);
        chk("bp_ovf", bus.ovf_err, 1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_accept", bus.out_valid, 0);
        chk("bp_ovf_sticky", bus.ovf_err, 1);

        // Reset mid-element abandons the partial sum.
        drive(1'b1, 100, 4, 0, 0, 0);
        tick();
        tick();
        chk("rst_mid_chunk", bus.chunk_idx, 2);
        drive(1'b0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        chk("rst2_out_data", bus.out_data, 0);
        chk("rst2_out_valid", bus.out_valid, 0);
        chk("rst2_chunk_idx", bus.chunk_idx, 0);
        chk("rst2_ovf_err", bus.ovf_err, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1, 4, 0, 0, 0);
            tick();
        end
        drive(1'b0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst2_valid", bus.out_valid, 1);
        chk("rst2_data", bus.out_data, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
